// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte producers.
// Optional macro UART_TX_SCHED_HDR_EN: prefix each grant with a header byte {1'b1, 0.., k}.
module uart_tx_sched #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          i_clk_sys,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [DATA_WIDTH-1:0]         o_data_tx,
    output logic                          o_data_valid,
    input  logic                          i_tx_ready,
    output logic                          o_busy,
    output logic                          o_timeout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t                 state;
    logic [IDX_W-1:0]       last;
    logic [IDX_W-1:0]       owner;
    logic [CNT_W-1:0]       cnt;

    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    logic [NUM_REQ-1:0]     pick_oh;
    logic [DATA_WIDTH-1:0]  pick_data;

`ifdef UART_TX_SCHED_HDR_EN
    logic                   hdr_phase;
    logic [DATA_WIDTH-1:0]  payload;
    logic [DATA_WIDTH-1:0]  hdr_byte;

    always_comb begin
        hdr_byte                  = '0;
        hdr_byte[DATA_WIDTH-1]    = 1'b1;
        hdr_byte[IDX_W-1:0]       = pick_idx;
    end
`endif

    // First valid requester searching upward from last+1, wrapping.
    always_comb begin
        int unsigned cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(last) + 1 + i) % NUM_REQ;
            if (!pick_found && i_req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
        pick_oh   = NUM_REQ'(1) << pick_idx;
        pick_data = i_req_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            state        <= S_IDLE;
            last         <= IDX_W'(NUM_REQ - 1);
            owner        <= '0;
            cnt          <= '0;
            o_req_ready  <= '0;
            o_grant      <= '0;
            o_data_tx    <= '0;
            o_data_valid <= 1'b0;
            o_busy       <= 1'b0;
            o_timeout    <= 1'b0;
`ifdef UART_TX_SCHED_HDR_EN
            hdr_phase    <= 1'b0;
            payload      <= '0;
`endif
        end else begin
            o_req_ready  <= '0;
            o_data_valid <= 1'b0;
            o_timeout    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_tx_ready && pick_found) begin
                        owner        <= pick_idx;
                        o_grant      <= pick_oh;
                        o_req_ready  <= pick_oh;
                        o_data_valid <= 1'b1;
                        o_busy       <= 1'b1;
                        state        <= S_ISSUE;
`ifdef UART_TX_SCHED_HDR_EN
                        o_data_tx    <= hdr_byte;
                        payload      <= pick_data;
                        hdr_phase    <= 1'b1;
`else
                        o_data_tx    <= pick_data;
`endif
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    // o_timeout is raised one cycle early so the re-strobe lands right after it.
                    if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        o_data_valid <= 1'b1;
                        state        <= S_ISSUE;
                    end else if (!i_tx_ready) begin
                        state <= S_WAIT_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(TIMEOUT_CYCLES - 2))
                            o_timeout <= 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (i_tx_ready) begin
`ifdef UART_TX_SCHED_HDR_EN
                        if (hdr_phase) begin
                            hdr_phase    <= 1'b0;
                            o_data_tx    <= payload;
                            o_data_valid <= 1'b1;
                            state        <= S_ISSUE;
                        end else begin
                            last    <= owner;
                            o_grant <= '0;
                            o_busy  <= 1'b0;
                            state   <= S_IDLE;
                        end
`else
                        last    <= owner;
                        o_grant <= '0;
                        o_busy  <= 1'b0;
                        state   <= S_IDLE;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched with a simple UART tx_ready model.
module tb_uart_tx_sched;

    localparam int NR    = 4;
    localparam int DW    = 8;
    localparam int TO    = 16;
    localparam int FRAME = 5;

`ifdef UART_TX_SCHED_HDR_EN
    localparam int         NFR      = 2;
    localparam logic [7:0] T1_FIRST = 8'h81;
    localparam logic [7:0] T5_FIRST = 8'h82;
    localparam logic [7:0] T6_FIRST = 8'h80;
`else
    localparam int         NFR      = 1;
    localparam logic [7:0] T1_FIRST = 8'h3C;
    localparam logic [7:0] T5_FIRST = 8'hA5;
    localparam logic [7:0] T6_FIRST = 8'h33;
`endif

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     grant;
    logic [DW-1:0]     data_tx;
    logic              data_valid;
    logic              tx_ready;
    logic              busy;
    logic              timeout;

    uart_tx_sched #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk_sys   (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ready (req_ready),
        .o_grant     (grant),
        .o_data_tx   (data_tx),
        .o_data_valid(data_valid),
        .i_tx_ready  (tx_ready),
        .o_busy      (busy),
        .o_timeout   (timeout)
    );

    typedef struct {
        int         k;
        logic [7:0] d;
    } sb_t;

    sb_t sb[$];
    int  order_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    bit  mon_en = 0;
    bit  uart_mode = 0;
    int  rem[NR];
    int  n_issue = 0;
    int  n_rr = 0;
    bit  pend = 0;
    int  pend_k = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic present(input int k, input logic [7:0] d);
        req_data[k*DW +: DW] = d;
        req_valid[k]         = 1'b1;
        sb.push_back('{k, d});
    endtask

    task automatic sb_pop(input int k, input logic [7:0] got, input string tag);
        int idx;
        idx = -1;
        foreach (sb[i]) if (idx < 0 && sb[i].k == k) idx = i;
        if (idx < 0) begin
            chk({tag, "_unexpected_requester"}, k, 32'hFFFF_FFFF);
        end else begin
            chk(tag, got, sb[idx].d);
            sb.delete(idx);
        end
    endtask

    function automatic int oh2i(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic do_reset();
        mon_en    = 0;
        uart_mode = 0;
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        tx_ready  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        order_q.delete();
        n_issue = 0;
        n_rr    = 0;
        pend    = 0;
        foreach (rem[k]) rem[k] = 0;
    endtask

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        while ((busy || req_valid != 0 || sb.size() != 0) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_sb_left"}, sb.size(), 0);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_order_left"}, order_q.size(), 0);
    endtask

    // Monitor and producer share one process so pops and re-presents stay ordered.
    initial begin : agent
        int k;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (req_ready != 0) n_rr++;
                if (data_valid) begin
                    n_issue++;
                    if (req_ready != 0) begin
                        k = oh2i(grant);
                        chk("ready_eq_grant", req_ready, grant);
                        if (order_q.size() > 0) chk("order", k, order_q.pop_front());
`ifdef UART_TX_SCHED_HDR_EN
                        chk("hdr_byte", data_tx, 32'h80 | k);
                        pend   = 1;
                        pend_k = k;
`else
                        sb_pop(k, data_tx, "payload");
`endif
                    end else begin
`ifdef UART_TX_SCHED_HDR_EN
                        if (pend) begin
                            sb_pop(pend_k, data_tx, "payload");
                            pend = 0;
                        end else begin
                            chk("unexpected_retry", data_valid, 0);
                        end
`else
                        chk("unexpected_retry", data_valid, 0);
`endif
                    end
                end
                for (int j = 0; j < NR; j++) begin
                    if (req_ready[j]) begin
                        if (rem[j] > 0) begin
                            rem[j]--;
                            present(j, 8'($urandom));
                        end else begin
                            req_valid[j] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // UART model: drops tx_ready one cycle after each strobe, holds it low for a frame.
    initial begin : uart_model
        forever begin
            @(negedge clk);
            if (uart_mode && data_valid) begin
                @(negedge clk);
                tx_ready = 1'b0;
                repeat (FRAME) @(negedge clk);
                tx_ready = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] first;
        int         t;
        int         early;
        clk       = 1'b0;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_ready  = 1'b1;

        do_reset();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_grant", grant, 0);
        chk("rst_data_tx", data_tx, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);

        // Single request, one-cycle latency
        do_reset();
        mon_en    = 1;
        uart_mode = 1;
        order_q.push_back(1);
        present(1, 8'h3C);
        @(negedge clk);
        chk("t1_req_ready", req_ready, 4'b0010);
        chk("t1_grant", grant, 4'b0010);
        chk("t1_data_valid", data_valid, 1);
        chk("t1_data_tx", data_tx, T1_FIRST);
        drain("t1");
        chk("t1_issues", n_issue, NFR);
        chk("t1_pulses", n_rr, 1);

        // All four continuously valid
        do_reset();
        mon_en    = 1;
        uart_mode = 1;
        foreach (rem[k]) rem[k] = 0;
        rem[0] = 1;
        order_q = '{0, 1, 2, 3, 0};
        for (int k = 0; k < NR; k++) present(k, 8'(8'h10 + k));
        drain("t2");
        chk("t2_issues", n_issue, 5 * NFR);
        chk("t2_pulses", n_rr, 5);

        // Requesters 0 and 2 only
        do_reset();
        mon_en    = 1;
        uart_mode = 1;
        rem[0] = 1;
        rem[2] = 1;
        order_q = '{0, 2, 0, 2};
        present(0, 8'h55);
        present(2, 8'hAA);
        drain("t3");
        chk("t3_issues", n_issue, 4 * NFR);
        chk("t3_pulses", n_rr, 4);

        // Timeout and retry with tx_ready stuck high
        do_reset();
        present(3, 8'h5A);
        @(negedge clk);
        chk("t4_req_ready", req_ready, 4'b1000);
        chk("t4_data_valid", data_valid, 1);
        first        = data_tx;
        req_valid[3] = 1'b0;
        t     = 0;
        early = 0;
        while (!timeout && t < 40) begin
            @(negedge clk);
            t++;
            if (data_valid || req_ready != 0) early++;
        end
        chk("t4_timeout_cycle", t, TO);
        chk("t4_no_early_issue", early, 0);
        @(negedge clk);
        chk("t4_retry_valid", data_valid, 1);
        chk("t4_retry_data", data_tx, first);
        chk("t4_retry_no_ready", req_ready, 0);
        chk("t4_timeout_single", timeout, 0);
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        sb.delete();
        uart_mode = 1;
        tx_ready  = 1'b1;
        drain("t4");

        // Requester 2 byte 0xA5 (header first when enabled)
        do_reset();
        mon_en    = 1;
        uart_mode = 1;
        order_q.push_back(2);
        present(2, 8'hA5);
        @(negedge clk);
        chk("t5_first_byte", data_tx, T5_FIRST);
        drain("t5");
        chk("t5_issues", n_issue, NFR);
        chk("t5_pulses", n_rr, 1);

        // Reset in WAIT_DONE while the frame is still in flight
        do_reset();
        present(2, 8'h11);
        @(negedge clk);
        chk("t6_issue", req_ready, 4'b0100);
        req_data[7:0]  = 8'h33;
        req_data[15:8] = 8'h22;
        req_valid      = 4'b0011;
        tx_ready       = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_in_frame", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_outputs", {req_ready, grant, data_tx, data_valid, busy, timeout}, 0);
        rst   = 1'b0;
        early = 0;
        repeat (6) begin
            @(negedge clk);
            if (data_valid || busy) early++;
        end
        chk("t6_hold_until_ready", early, 0);
        tx_ready = 1'b1;
        @(negedge clk);
        chk("t6_prefers_req0", req_ready, 4'b0001);
        chk("t6_data_tx", data_tx, T6_FIRST);
        req_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
